fifo_stream_reader: RTL and testbench

Read-side engine for the team's FIFO block: pulls words out of a FIFO read port (rdreq/q/rdempty) and presents them as a registered valid/ready stream with packet framing. Hides FIFO read latency (show-ahead or normal mode) behind a 2-entry output buffer. Sustains one beat per clock when the FIFO is non-empty and the sink is ready. Sits between a fifo_top read port and any downstream stream consumer in the same clock domain.

---
 rtl/fifo_stream_reader_pkg.sv | 22 ++
 rtl/fifo_stream_reader_if.sv | 29 ++
 rtl/fifo_stream_reader_skid.sv | 76 +++++++
 rtl/fifo_stream_reader.sv | 111 +++++++++++
 tb/tb_fifo_stream_reader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_stream_pkg                                        |
// | Description : Shared types and constants for the FIFO stream reader: |
// |               output-buffer occupancy states and stat widths.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fifo_stream_pkg;

   // Occupancy of the 2-entry output buffer; the encoding doubles as the count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

   localparam int STAT_BEATS_W  = 32;
   localparam int STAT_PKTS_W   = 16;
   localparam int STAT_STALLS_W = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_stream_reader_if                                  |
// | Description : FIFO read port plus valid/ready output stream.         |
// |               master = the reader engine, slave = FIFO + sink side.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface fifo_stream_reader_if #(
   parameter int DataWidth = 32
);
   logic                 rdempty;
   logic [DataWidth-1:0] q;
   logic                 rdreq;
   logic                 out_valid;
   logic [DataWidth-1:0] out_data;
   logic                 out_last;
   logic                 out_ready;

   modport master (
      input  rdempty, q, out_ready,
      output rdreq, out_valid, out_data, out_last
   );

   modport slave (
      output rdempty, q, out_ready,
      input  rdreq, out_valid, out_data, out_last
   );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_stream_skid                                       |
// | Description : 2-entry in-order output buffer. Head entry drives the  |
// |               stream; tail absorbs one extra word while stalled.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fifo_stream_skid
   import fifo_stream_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  wire logic                 CLK,
   input  wire logic                 Reset,
   input  wire logic                 push,
   input  wire logic [DataWidth-1:0] push_data,
   input  wire logic                 pop,
   output logic      [1:0]           occ,
   output logic                      head_valid,
   output logic      [DataWidth-1:0] head_data
);

   buf_state_t           r_state;
   buf_state_t           w_next;
   logic [DataWidth-1:0] r_head;
   logic [DataWidth-1:0] r_tail;

   // Occupancy state register.
   always_ff @(posedge CLK) begin
      if (Reset) r_state <= EMPTY;
      else       r_state <= w_next;
   end

   // Next occupancy from push/pop; push and pop together keep the count.
   always_comb begin
      w_next = r_state;
      case (r_state)
         EMPTY:   if (push) w_next = ONE;
         ONE: begin
            if (push && !pop)      w_next = TWO;
            else if (pop && !push) w_next = EMPTY;
         end
         TWO:     if (pop && !push) w_next = ONE;
         default: w_next = EMPTY;
      endcase
   end

   // Entry storage: keep words in arrival order, head always oldest.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case (r_state)
            EMPTY: if (push) r_head <= push_data;
            ONE: begin
               if (push && pop) r_head <= push_data;
               else if (push)   r_tail <= push_data;
            end
            TWO: begin
               if (pop) begin
                  r_head <= r_tail;
                  if (push) r_tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign occ        = r_state;
   assign head_valid = (r_state != EMPTY);
   assign head_data  = r_head;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_stream_reader                                     |
// | Description : Pulls words from a FIFO read port and presents them as |
// |               a framed valid/ready stream, hiding read latency with  |
// |               a 2-entry buffer. Optional statistics counters are     |
// |               built when FIFO_STREAM_STATS_EN is defined.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int ShowHead  = 1,
   parameter int DataWidth = 32,
   parameter int PacketLen = 16,
   parameter int LenWidth  = 4
) (
   input  wire logic                     CLK,
   input  wire logic                     Reset,
`ifdef FIFO_STREAM_STATS_EN
   output logic [STAT_BEATS_W-1:0]       stat_beats,
   output logic [STAT_PKTS_W-1:0]        stat_pkts,
   output logic [STAT_STALLS_W-1:0]      stat_stalls,
`endif
   fifo_stream_reader_if.master          bus
);

   localparam logic [LenWidth-1:0] LAST_IDX = LenWidth'(PacketLen - 1);

   logic [1:0]           w_occ;
   logic                 w_head_valid;
   logic [DataWidth-1:0] w_head_data;
   logic                 w_inflight;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_rdreq;
   logic [2:0]           w_credit;
   logic [LenWidth-1:0]  r_cnt;

   assign w_pop    = w_head_valid && bus.out_ready;
   // Words held or on their way, after this cycle's pop leaves.
   assign w_credit = {1'b0, w_occ} + {2'b00, w_inflight} - {2'b00, w_pop};
   assign w_rdreq  = !bus.rdempty && (w_credit < 3'd2);

   generate
      if (ShowHead != 0) begin : g_show_ahead
         // q is already valid in the request cycle.
         assign w_inflight = 1'b0;
         assign w_push     = w_rdreq;
      end else begin : g_normal
         logic r_inflight;
         // Track the read whose data arrives on q next cycle.
         always_ff @(posedge CLK) begin
            if (Reset) r_inflight <= 1'b0;
            else       r_inflight <= w_rdreq;
         end
         assign w_inflight = r_inflight;
         assign w_push     = r_inflight;
      end
   endgenerate

   fifo_stream_skid #(
      .DataWidth (DataWidth)
   ) u_skid (
      .CLK        (CLK),
      .Reset      (Reset),
      .push       (w_push),
      .push_data  (bus.q),
      .pop        (w_pop),
      .occ        (w_occ),
      .head_valid (w_head_valid),
      .head_data  (w_head_data)
   );

   // Beat position within the packet, advanced on every accepted beat.
   always_ff @(posedge CLK) begin
      if (Reset)      r_cnt <= '0;
      else if (w_pop) r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + LenWidth'(1);
   end

   assign bus.rdreq     = w_rdreq;
   assign bus.out_valid = w_head_valid;
   assign bus.out_data  = w_head_data;
   assign bus.out_last  = w_head_valid && (r_cnt == LAST_IDX);

`ifdef FIFO_STREAM_STATS_EN
   logic [STAT_BEATS_W-1:0]  r_beats;
   logic [STAT_PKTS_W-1:0]   r_pkts;
   logic [STAT_STALLS_W-1:0] r_stalls;

   // Beat and packet totals wrap; stall count sticks at all-ones.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_beats  <= '0;
         r_pkts   <= '0;
         r_stalls <= '0;
      end else begin
         if (w_pop) r_beats <= r_beats + STAT_BEATS_W'(1);
         if (w_pop && bus.out_last) r_pkts <= r_pkts + STAT_PKTS_W'(1);
         if (w_head_valid && !bus.out_ready && (r_stalls != {STAT_STALLS_W{1'b1}}))
            r_stalls <= r_stalls + STAT_STALLS_W'(1);
      end
   end

   assign stat_beats  = r_beats;
   assign stat_pkts   = r_pkts;
   assign stat_stalls = r_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fifo_stream_reader                                  |
// | Description : Drives a show-ahead and a normal-mode reader from the  |
// |               same word source and sink pattern; a word-count model  |
// |               predicts every output each cycle.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fifo_stream_reader;

   localparam int DW = 32;
   localparam int PL = 4;
   localparam int LW = 2;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic hold  = 1'b0;
   logic ready = 1'b0;

   int wr_cnt  = 0;
   int rd_ptr0 = 0;
   int rd_ptr1 = 0;
   int total   = 0;
   int bad     = 0;

   // Model: exp_ptr = index of the next word the lane must present.
   int   exp_ptr  [2] = '{0, 0};
   int   beat     [2] = '{0, 0};
   int   lasts    [2] = '{0, 0};
   logic ack_prev [2] = '{1'b0, 1'b0};

`ifdef FIFO_STREAM_STATS_EN
   int m_beats  [2] = '{0, 0};
   int m_pkts   [2] = '{0, 0};
   int m_stalls [2] = '{0, 0};
   logic [31:0] sb0, sb1;
   logic [15:0] sp0, sp1, ss0, ss1;
`endif

   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DataWidth(DW)) bus0 ();
   fifo_stream_reader_if #(.DataWidth(DW)) bus1 ();

   fifo_stream_reader #(
      .ShowHead(1), .DataWidth(DW), .PacketLen(PL), .LenWidth(LW)
   ) dut_sa (
      .CLK         (clk),
      .Reset       (rst),
`ifdef FIFO_STREAM_STATS_EN
      .stat_beats  (sb0),
      .stat_pkts   (sp0),
      .stat_stalls (ss0),
`endif
      .bus         (bus0)
   );

   fifo_stream_reader #(
      .ShowHead(0), .DataWidth(DW), .PacketLen(PL), .LenWidth(LW)
   ) dut_nm (
      .CLK         (clk),
      .Reset       (rst),
`ifdef FIFO_STREAM_STATS_EN
      .stat_beats  (sb1),
      .stat_pkts   (sp1),
      .stat_stalls (ss1),
`endif
      .bus         (bus1)
   );

   function automatic logic [31:0] word(input int k);
      return 32'(k + 1);
   endfunction

   // FIFO models: word k of the source is value k+1.
   assign bus0.rdempty   = hold || (rd_ptr0 == wr_cnt);
   assign bus0.q         = (rd_ptr0 == wr_cnt) ? 32'd0 : word(rd_ptr0);
   assign bus1.rdempty   = hold || (rd_ptr1 == wr_cnt);
   assign bus0.out_ready = ready;
   assign bus1.out_ready = ready;

   always @(posedge clk) if (bus0.rdreq && !bus0.rdempty) rd_ptr0 <= rd_ptr0 + 1;

   always @(posedge clk) begin
      if (bus1.rdreq && !bus1.rdempty) begin
         bus1.q  <= word(rd_ptr1);
         rd_ptr1 <= rd_ptr1 + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of one lane: check against the word-count model, then advance it.
   task automatic lane(input int ln, input int rdp, input logic rdempty, input logic rdreq,
                       input logic valid, input logic last, input logic [31:0] data);
      int   held;
      logic pop;
      logic ack;
      pop  = valid && ready;
      ack  = rdreq && !rdempty;
      held = rdp - exp_ptr[ln];
      if (rst) begin
         exp_ptr[ln]  = rdp + (ack ? 1 : 0);
         beat[ln]     = 0;
         ack_prev[ln] = 1'b0;
`ifdef FIFO_STREAM_STATS_EN
         m_beats[ln]  = 0;
         m_pkts[ln]   = 0;
         m_stalls[ln] = 0;
`endif
      end else begin
         chk($sformatf("rdreq%0d", ln), {31'd0, rdreq},
             {31'd0, (!rdempty && ((held - (pop ? 1 : 0)) < 2))});
         chk($sformatf("valid%0d", ln), {31'd0, valid},
             {31'd0, ((held - ((ln == 1 && ack_prev[ln]) ? 1 : 0)) > 0)});
         if (valid) begin
            chk($sformatf("data%0d", ln), data, word(exp_ptr[ln]));
            chk($sformatf("last%0d", ln), {31'd0, last}, {31'd0, (beat[ln] == PL - 1)});
         end else begin
            chk($sformatf("last_idle%0d", ln), {31'd0, last}, 32'd0);
         end
`ifdef FIFO_STREAM_STATS_EN
         if (valid && !ready && m_stalls[ln] < 65535) m_stalls[ln]++;
         if (pop) begin
            m_beats[ln]++;
            if (beat[ln] == PL - 1) m_pkts[ln]++;
         end
`endif
         if (pop) begin
            exp_ptr[ln]++;
            if (last) lasts[ln]++;
            beat[ln] = (beat[ln] + 1) % PL;
         end
         ack_prev[ln] = ack;
      end
   endtask

   // Compare process: outputs settle well before the falling edge.
   always @(negedge clk) begin
`ifdef FIFO_STREAM_STATS_EN
      if (!rst) begin
         chk("stat_beats0",  sb0, 32'(m_beats[0]));
         chk("stat_beats1",  sb1, 32'(m_beats[1]));
         chk("stat_pkts0",   {16'd0, sp0}, 32'(m_pkts[0]));
         chk("stat_pkts1",   {16'd0, sp1}, 32'(m_pkts[1]));
         chk("stat_stalls0", {16'd0, ss0}, 32'(m_stalls[0]));
         chk("stat_stalls1", {16'd0, ss1}, 32'(m_stalls[1]));
      end
`endif
      lane(0, rd_ptr0, bus0.rdempty, bus0.rdreq, bus0.out_valid, bus0.out_last, bus0.out_data);
      lane(1, rd_ptr1, bus1.rdempty, bus1.rdreq, bus1.out_valid, bus1.out_last, bus1.out_data);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Wait until both lanes have presented every written word.
   task automatic drain(input string nm, input int budget, input bit toggle);
      int cyc;
      cyc = 0;
      while (!(exp_ptr[0] == wr_cnt && exp_ptr[1] == wr_cnt) && cyc < budget) begin
         if (toggle) ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         tick();
         cyc++;
      end
      ready = 1'b1;
      chk(nm, {31'd0, (exp_ptr[0] == wr_cnt && exp_ptr[1] == wr_cnt)}, 32'd1);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int l0, l1;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Reset values.
      @(negedge clk);
      chk("rst_rdreq0", {31'd0, bus0.rdreq}, 32'd0);
      chk("rst_rdreq1", {31'd0, bus1.rdreq}, 32'd0);
      chk("rst_valid0", {31'd0, bus0.out_valid}, 32'd0);
      chk("rst_valid1", {31'd0, bus1.out_valid}, 32'd0);
      chk("rst_data0",  bus0.out_data, 32'd0);
      chk("rst_data1",  bus1.out_data, 32'd0);
      chk("rst_last0",  {31'd0, bus0.out_last}, 32'd0);
      chk("rst_last1",  {31'd0, bus1.out_last}, 32'd0);

      // Eight preloaded words, sink always ready: literal timeline.
      tick();
      ready  = 1'b1;
      wr_cnt = 8;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("t1_rdreq0_c%0d", c), {31'd0, bus0.rdreq}, {31'd0, (c <= 7)});
         chk($sformatf("t1_rdreq1_c%0d", c), {31'd0, bus1.rdreq}, {31'd0, (c <= 7)});
         chk($sformatf("t1_valid0_c%0d", c), {31'd0, bus0.out_valid}, {31'd0, (c >= 1 && c <= 8)});
         chk($sformatf("t1_valid1_c%0d", c), {31'd0, bus1.out_valid}, {31'd0, (c >= 2 && c <= 9)});
         if (c >= 1 && c <= 8) chk($sformatf("t1_data0_c%0d", c), bus0.out_data, 32'(c));
         if (c >= 2 && c <= 9) chk($sformatf("t1_data1_c%0d", c), bus1.out_data, 32'(c - 1));
         tick();
      end

      // Twenty words with the sink toggling 1,0,0,1.
      wr_cnt += 20;
      drain("drain_toggle", 300, 1'b1);

      // Packet framing over twelve beats (28 beats so far: aligned).
      l0 = lasts[0];
      l1 = lasts[1];
      wr_cnt += 12;
      drain("drain_packet", 100, 1'b0);
      chk("pkt_lasts0", 32'(lasts[0] - l0), 32'd3);
      chk("pkt_lasts1", 32'(lasts[1] - l1), 32'd3);
`ifdef FIFO_STREAM_STATS_EN
      chk("pkt_stat_beats0", sb0, 32'd40);
      chk("pkt_stat_beats1", sb1, 32'd40);
      chk("pkt_stat_pkts0",  {16'd0, sp0}, 32'd10);
      chk("pkt_stat_pkts1",  {16'd0, sp1}, 32'd10);
`endif

      // FIFO reports empty for five cycles mid-stream.
      wr_cnt += 10;
      repeat (3) tick();
      hold = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      chk("hold_valid0", {31'd0, bus0.out_valid}, 32'd0);
      chk("hold_valid1", {31'd0, bus1.out_valid}, 32'd0);
      chk("hold_rdreq0", {31'd0, bus0.rdreq}, 32'd0);
      chk("hold_rdreq1", {31'd0, bus1.rdreq}, 32'd0);
      tick();
      hold = 1'b0;
      drain("drain_hold", 100, 1'b0);

      // Fill both buffers with the sink stalled, then reset.
      ready = 1'b0;
      wr_cnt += 6;
      repeat (6) tick();
      @(negedge clk);
      chk("full_valid0", {31'd0, bus0.out_valid}, 32'd1);
      chk("full_valid1", {31'd0, bus1.out_valid}, 32'd1);
      chk("full_rdreq0", {31'd0, bus0.rdreq}, 32'd0);
      chk("full_rdreq1", {31'd0, bus1.rdreq}, 32'd0);
      tick();
      rst  = 1'b1;
      hold = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("prst_valid0", {31'd0, bus0.out_valid}, 32'd0);
      chk("prst_valid1", {31'd0, bus1.out_valid}, 32'd0);
      chk("prst_rdreq0", {31'd0, bus0.rdreq}, 32'd0);
      chk("prst_rdreq1", {31'd0, bus1.rdreq}, 32'd0);
      tick();
      hold  = 1'b0;
      ready = 1'b1;
      wr_cnt += 5;
      drain("drain_restart", 100, 1'b0);
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
